// File: rtl/serial_comp_ctrl.sv
// Sequencer for the bit-serial two's complementer: loads a parallel word, shifts it out LSB-first, collects the serial result.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one word per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is sampled only in IDLE or DONE and is ignored (not queued) while shifting.
module serial_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ovf,
    output logic             zero,
    output logic             comp_x,
    output logic             comp_reset,
    input  logic             comp_y
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf_c;
    logic             r_zero_c;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_comp_reset;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // start is only honoured when no word is in flight
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // incoming serial bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB
    assign w_res_nxt = (r_res >> 1) | {comp_y, {(WIDTH-1){1'b0}}};

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
            S_SHIFT: w_state_nxt = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state-decoded outputs; comp_x is forced low outside SHIFT
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        comp_x = 1'b0;
        case (r_state)
            S_SHIFT: begin
                busy   = 1'b1;
                comp_x = r_sh[0];
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // complementer reset follows next-state so it is released exactly for SHIFT cycles, glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_comp_reset <= 1'b0;
        end else begin
            r_comp_reset <= (w_state_nxt == S_SHIFT);
        end
    end

    // operand/result shifting, bit counter and flag candidates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh     <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_ovf_c  <= 1'b0;
            r_zero_c <= 1'b0;
        end else if (w_accept) begin
            r_sh     <= din;
            r_res    <= '0;
            r_cnt    <= '0;
            r_ovf_c  <= (din == {1'b1, {(WIDTH-1){1'b0}}});
            r_zero_c <= (din == '0);
        end else if (r_state == S_SHIFT) begin
            r_sh  <= r_sh >> 1;
            r_res <= w_res_nxt;
            // hold on the final bit so the counter never wraps
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // publish result and flags on the edge that captures the last bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_dout <= w_res_nxt;
            r_ovf  <= r_ovf_c;
            r_zero <= r_zero_c;
        end
    end

    assign dout       = r_dout;
    assign ovf        = r_ovf;
    assign zero       = r_zero;
    assign comp_reset = r_comp_reset;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl with a behavioural serial complementer attached.
// Latency: checks done arrives 8 cycles after the accepting edge, 9 cycles apart back-to-back.
// Backpressure: exercises ignored mid-shift start and mid-shift reset abort.
module tb_serial_comp_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       ovf;
    logic       zero;
    logic       comp_x;
    logic       comp_reset;
    logic       comp_y;

    int n_chk;
    int n_bad;
    int n_done;
    logic [9:0] sb_q[$];

    serial_comp_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .ovf        (ovf),
        .zero       (zero),
        .comp_x     (comp_x),
        .comp_reset (comp_reset),
        .comp_y     (comp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // serial complementer: pass bits through up to and including the first 1, invert afterwards
    logic m_seen;
    always_ff @(posedge clk or negedge comp_reset) begin
        if (!comp_reset) m_seen <= 1'b0;
        else if (comp_x) m_seen <= 1'b1;
    end
    assign comp_y = m_seen ? ~comp_x : comp_x;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] expect_of(input logic [7:0] d);
        logic [7:0] neg;
        neg = ~d + 8'd1;
        return {(d == 8'h80), (d == 8'h00), neg};
    endfunction

    // scoreboard: every done pops one expected word
    always @(negedge clk) begin
        if (reset && done) begin
            logic [9:0] e;
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("dout", {24'd0, dout}, {24'd0, e[7:0]});
                chk("zero", {31'd0, zero}, {31'd0, e[8]});
                chk("ovf",  {31'd0, ovf},  {31'd0, e[9]});
            end
        end
    end

    // drive one start pulse; optionally record the expected result
    task automatic send(input logic [7:0] d, input bit push);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        if (push) sb_q.push_back(expect_of(d));
        #1;
        start = 1'b0;
        din   = 8'($urandom);
    endtask

    // count cycles (negedges) until done; also count comp_reset-high cycles before it
    task automatic wait_done(output int k, output int crh);
        k   = 0;
        crh = 0;
        while (k < 30) begin
            @(negedge clk);
            if (done) begin
                chk("comp_reset_in_done", {31'd0, comp_reset}, 32'd0);
                return;
            end
            if (comp_reset) crh++;
            k++;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        int crh;
        int nd0;
        n_chk  = 0;
        n_bad  = 0;
        n_done = 0;
        reset  = 1'b0;
        start  = 1'b0;
        din    = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_done",   {31'd0, done},       32'd0);
        chk("rst_dout",   {24'd0, dout},       32'd0);
        chk("rst_ovf",    {31'd0, ovf},        32'd0);
        chk("rst_zero",   {31'd0, zero},       32'd0);
        chk("rst_comp_x", {31'd0, comp_x},     32'd0);
        chk("rst_comp_r", {31'd0, comp_reset}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single word: latency and comp_reset window
        send(8'h05, 1'b1);
        wait_done(k, crh);
        chk("lat_05", k, 32'd8);
        chk("crh_05", crh, 32'd8);
        repeat (2) @(negedge clk);

        // flag corner cases
        send(8'h00, 1'b1); wait_done(k, crh);
        send(8'h80, 1'b1); wait_done(k, crh);
        send(8'h01, 1'b1); wait_done(k, crh);
        repeat (2) @(negedge clk);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        din   = 8'h0C;
        @(posedge clk);
        sb_q.push_back(expect_of(8'h0C));
        #1 din = 8'h7F;
        wait_done(k, crh);
        chk("b2b_lat1", k, 32'd8);
        chk("b2b_crh1", crh, 32'd8);
        sb_q.push_back(expect_of(8'h7F));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(k, crh);
        // done pulses are one wait (8) plus the DONE cycle itself apart
        chk("b2b_lat2", k + 1, 32'd9);
        chk("b2b_crh2", crh, 32'd8);
        repeat (2) @(negedge clk);

        // start mid-SHIFT must be ignored
        nd0 = n_done;
        send(8'h21, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        din   = 8'h99;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, crh);
        repeat (12) @(negedge clk);
        chk("ignore_cnt", n_done - nd0, 32'd1);

        // reset asserted while bit 4 of 0x33 is on comp_x
        nd0 = n_done;
        send(8'h33, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_abort_x", {31'd0, comp_x}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy},       32'd0);
        chk("abort_cr",   {31'd0, comp_reset}, 32'd0);
        chk("abort_x",    {31'd0, comp_x},     32'd0);
        chk("abort_done", {31'd0, done},       32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_nodone", n_done - nd0, 32'd0);
        send(8'h33, 1'b1);
        wait_done(k, crh);
        repeat (2) @(negedge clk);

        // random words
        for (int i = 0; i < 200; i++) begin
            send(8'($urandom), 1'b1);
            wait_done(k, crh);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_comp_ctrl.md
# serial_comp_ctrl

Sequencer for the bit-serial two's complementer (`compliment`). It accepts a parallel WIDTH-bit word on a start strobe, resets the complementer, and shifts the word into it LSB-first. It collects the serial result back into a parallel word and presents it with a one-cycle done strobe. It sits between parallel register-level logic and the serial complementer, and is the only driver of the complementer's `x` and `reset` inputs.

## Interface
- `WIDTH`, default 8: word width in bits, minimum 2.
- `clk`  in  1  rising-edge clock, shared with the complementer.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe. Sampled only in IDLE or DONE.
- `din`  in  WIDTH  operand, sampled on the edge that accepts `start`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `dout` and the flags are valid from this cycle onward.
- `dout`  out  WIDTH  two's complement of the accepted `din`. Holds until the next done.
- `ovf`  out  1  accepted `din` was the most-negative value (MSB 1, rest 0). Updates with `dout`.
- `zero`  out  1  accepted `din` was all-zero. Updates with `dout`.
- `comp_x`  out  1  serial bit to the complementer's `x`.
- `comp_reset`  out  1  to the complementer's `reset` (active-low). Registered, glitch-free.
- `comp_y`  in  1  complementer's `y`.

## Operation
- Complementer contract:
  - `comp_y` is combinational from `comp_x` and the complementer state: it equals `comp_x` up to and including the first 1 since reset, and `~comp_x` afterwards.
  - The complementer's state updates on the rising `clk` edge.
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - If `start`=1, load the shift register with `din`, clear the bit counter, register `ovf`/`zero` candidates, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - `comp_x` = shift register bit 0.
  - On each edge, sample `comp_y` into the MSB of the result register, shift that register right, shift the operand register right, and increment the counter.
  - After the edge that captures bit WIDTH-1, go to DONE. On that edge, copy the result to `dout` and the candidates to `ovf`/`zero`.
- DONE:
  - `done`=1 for this one cycle.
  - If `start`=1, accept it exactly as in IDLE and go to SHIFT (back-to-back). Otherwise go to IDLE.
- `start` is ignored in SHIFT; no queuing.
- `comp_reset` is registered from next-state: 1 exactly during SHIFT cycles, 0 otherwise. The complementer is therefore cleared before every word.
- `comp_x` is 0 outside SHIFT.
- Counter width is clog2(WIDTH). Compare against WIDTH-1; the counter never wraps.

## Timing
- Reset values: `busy`=0, `done`=0, `dout`=0, `ovf`=0, `zero`=0, `comp_x`=0, `comp_reset`=0. State is IDLE, all internal registers are 0.
- Let start be accepted at edge E0:
  - SHIFT occupies the WIDTH cycles following E0.
  - Bit i is driven in cycle i after E0 and captured at edge E(i+1).
  - `done` is high in the cycle after E(WIDTH).
- Latency: WIDTH cycles from the accepting edge to `done`.
- Throughput: one word per WIDTH+1 cycles when back-to-back.
- `comp_reset` is low for at least one cycle between consecutive words (the DONE cycle).
- Reset asserted mid-SHIFT:
  - All outputs go immediately to their reset values, and `comp_reset` drops to 0.
  - No `done` is produced and the partial result is discarded.
- `start` asserted in the same cycle that reset deasserts is not accepted. The first accept is on the first edge with `reset`=1 sampled.

## Test plan
- WIDTH=8, `din`=0x05, single start → `done` 8 cycles after the accepting edge, `dout`=0xFB, `ovf`=0, `zero`=0, `comp_reset` high exactly 8 cycles.
- `din`=0x00 → `dout`=0x00, `zero`=1. Then `din`=0x80 → `dout`=0x80, `ovf`=1. Then `din`=0x01 → `dout`=0xFF with both flags 0.
- Back-to-back: `start` held high with `din`=0x0C then 0x7F → `done` pulses 9 cycles apart, results 0xF4 then 0x81, `comp_reset` low exactly in each DONE cycle.
- `start` pulsed mid-SHIFT with a different `din` → ignored; `dout` matches the first operand only; exactly one `done`.
- `reset` pulled low at bit 4 of `din`=0x33 → `busy`, `comp_reset` and `comp_x` go to 0 immediately, no `done`. A new start with 0x33 after release → `dout`=0xCD.
- Scoreboard with random 8-bit operands: `dout` == (~din+1) mod 256 for 200 words, with the complementer model attached.
